sms_mapper: RTL and testbench

//   Sega-style memory mapper between the tv80n CPU bus and the cartridge ROM store (SDRAM or BRAM), system RAM and cartridge RAM.

---
 rtl/sms_mapper.sv | 184 ++++++++++++++++++
 tb/tb_sms_mapper.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sms_mapper.sv
`default_nettype none
// ============================================================================
// Module      : sms_mapper
// Description : Sega-style memory mapper sitting between the tv80n CPU bus
//               and the cartridge ROM store, system RAM and cartridge RAM.
//               Holds the four paging registers at FFFC-FFFF and translates
//               each 16-bit CPU address into a wide ROM byte address or a
//               RAM select.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   cpu_clk_edge  one-clk pulse per CPU clock-enable edge; qualifies writes
//   cpu_addr      CPU address bus
//   cpu_dout      CPU write data
//   cpu_mem_wr    memory write in progress (level)
//   bank_mask     ROM-size mask (2^n-1 banks), ANDed into every bank number
//   rom_addr      byte address into the ROM store
//   rom_sel       access targets ROM
//   cart_ram_sel  access targets the 32K cartridge RAM
//   cart_ram_addr cartridge RAM byte address
//   sys_ram_sel   access targets the 8K system RAM (C000-FFFF)
//   sys_ram_addr  system RAM byte address (E000-FFFF mirrors C000-DFFF)
//   map_ctrl      FFFC register (diagnostics)
//   map_bank0/1/2 FFFD/FFFE/FFFF registers (diagnostics)
//
// Revision    : 1.0  initial release
// ============================================================================
module sms_mapper #(
  parameter int ROM_ADDR_BITS = 24,
  parameter int BANK_BITS     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_clk_edge,
  input  logic [15:0]              cpu_addr,
  input  logic [7:0]               cpu_dout,
  input  logic                     cpu_mem_wr,
  input  logic [BANK_BITS-1:0]     bank_mask,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  output logic                     rom_sel,
  output logic                     cart_ram_sel,
  output logic [14:0]              cart_ram_addr,
  output logic                     sys_ram_sel,
  output logic [12:0]              sys_ram_addr,
  output logic [7:0]               map_ctrl,
  output logic [BANK_BITS-1:0]     map_bank0,
  output logic [BANK_BITS-1:0]     map_bank1,
  output logic [BANK_BITS-1:0]     map_bank2
);

  // Mapper registers occupy the last four bytes of the address space.
  localparam logic [13:0] MAP_PAGE = 14'h3FFF;

  localparam logic [1:0] SEL_CTRL  = 2'd0;
  localparam logic [1:0] SEL_BANK0 = 2'd1;
  localparam logic [1:0] SEL_BANK1 = 2'd2;
  localparam logic [1:0] SEL_BANK2 = 2'd3;

  localparam logic [1:0] REGION_SLOT0 = 2'b00;
  localparam logic [1:0] REGION_SLOT1 = 2'b01;
  localparam logic [1:0] REGION_SLOT2 = 2'b10;

  localparam logic [BANK_BITS-1:0] BANK0_RST = BANK_BITS'(0);
  localparam logic [BANK_BITS-1:0] BANK1_RST = BANK_BITS'(1);
  localparam logic [BANK_BITS-1:0] BANK2_RST = BANK_BITS'(2);

  // --------------------------------------------------------------------------
  // Register write capture
  // --------------------------------------------------------------------------
  logic [7:0]           map_ctrl_q,  map_ctrl_d;
  logic [BANK_BITS-1:0] map_bank0_q, map_bank0_d;
  logic [BANK_BITS-1:0] map_bank1_q, map_bank1_d;
  logic [BANK_BITS-1:0] map_bank2_q, map_bank2_d;
  logic                 wr_done_q,   wr_done_d;

  logic wr_accept;
  logic map_hit;

  // A Z80 write cycle spans several cpu_clk_edge pulses; wr_done blocks
  // every pulse after the first until the write strobe drops.
  assign wr_accept = cpu_clk_edge & cpu_mem_wr & ~wr_done_q;
  assign map_hit   = (cpu_addr[15:2] == MAP_PAGE);

  always_comb begin
    map_ctrl_d  = map_ctrl_q;
    map_bank0_d = map_bank0_q;
    map_bank1_d = map_bank1_q;
    map_bank2_d = map_bank2_q;
    wr_done_d   = wr_done_q;

    if (!cpu_mem_wr) begin
      wr_done_d = 1'b0;
    end else if (wr_accept) begin
      wr_done_d = 1'b1;
      if (map_hit) begin
        case (cpu_addr[1:0])
          SEL_CTRL:  map_ctrl_d  = cpu_dout;
          SEL_BANK0: map_bank0_d = cpu_dout[BANK_BITS-1:0];
          SEL_BANK1: map_bank1_d = cpu_dout[BANK_BITS-1:0];
          SEL_BANK2: map_bank2_d = cpu_dout[BANK_BITS-1:0];
          default:   map_ctrl_d  = map_ctrl_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map_ctrl_q  <= 8'h00;
      map_bank0_q <= BANK0_RST;
      map_bank1_q <= BANK1_RST;
      map_bank2_q <= BANK2_RST;
      wr_done_q   <= 1'b0;
    end else begin
      map_ctrl_q  <= map_ctrl_d;
      map_bank0_q <= map_bank0_d;
      map_bank1_q <= map_bank1_d;
      map_bank2_q <= map_bank2_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign map_ctrl  = map_ctrl_q;
  assign map_bank0 = map_bank0_q;
  assign map_bank1 = map_bank1_q;
  assign map_bank2 = map_bank2_q;

  // --------------------------------------------------------------------------
  // Address decode (purely combinational, zero latency)
  // --------------------------------------------------------------------------
  logic [1:0]           region;
  logic                 unpaged;
  logic                 cart_ram_en;
  logic [BANK_BITS-1:0] bank_raw;
  logic [BANK_BITS-1:0] bank_eff;

  assign region      = cpu_addr[15:14];
  // The first 1K always comes from bank 0 so the interrupt vectors survive
  // any paging of slot 0.
  assign unpaged     = (region == REGION_SLOT0) && (cpu_addr[13:10] == 4'h0);
  assign cart_ram_en = map_ctrl_q[3];

  always_comb begin
    case (region)
      REGION_SLOT0: bank_raw = map_bank0_q;
      REGION_SLOT1: bank_raw = map_bank1_q;
      default:      bank_raw = map_bank2_q;
    endcase
  end

  // Oversized bank numbers wrap into the loaded ROM image.
  assign bank_eff = bank_raw & bank_mask;

  always_comb begin
    rom_addr = '0;
    if (unpaged) begin
      rom_addr[9:0] = cpu_addr[9:0];
    end else begin
      rom_addr[13:0]              = cpu_addr[13:0];
      rom_addr[BANK_BITS+13:14]   = bank_eff;
    end
  end

  always_comb begin
    rom_sel      = 1'b0;
    cart_ram_sel = 1'b0;
    sys_ram_sel  = 1'b0;
    case (region)
      REGION_SLOT0, REGION_SLOT1: rom_sel = 1'b1;
      REGION_SLOT2: begin
        if (cart_ram_en) cart_ram_sel = 1'b1;
        else             rom_sel      = 1'b1;
      end
      default: sys_ram_sel = 1'b1;
    endcase
  end

  // map_ctrl[2] picks which 16K half of the cartridge RAM appears in slot 2.
  assign cart_ram_addr = {map_ctrl_q[2], cpu_addr[13:0]};
  assign sys_ram_addr  = cpu_addr[12:0];

endmodule
`default_nettype wire

// File: tb/tb_sms_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_sms_mapper
// Description : Self-checking bench for sms_mapper. A behavioural model of
//               the paging registers and the memory map is compared against
//               the DUT on every falling clock edge; directed vectors add
//               hand-computed literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sms_mapper;

  localparam int RAB = 24;
  localparam int BB  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           cpu_clk_edge;
  logic [15:0]    cpu_addr;
  logic [7:0]     cpu_dout;
  logic           cpu_mem_wr;
  logic [BB-1:0]  bank_mask;
  logic [RAB-1:0] rom_addr;
  logic           rom_sel;
  logic           cart_ram_sel;
  logic [14:0]    cart_ram_addr;
  logic           sys_ram_sel;
  logic [12:0]    sys_ram_addr;
  logic [7:0]     map_ctrl;
  logic [BB-1:0]  map_bank0;
  logic [BB-1:0]  map_bank1;
  logic [BB-1:0]  map_bank2;

  sms_mapper #(.ROM_ADDR_BITS(RAB), .BANK_BITS(BB)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_clk_edge (cpu_clk_edge),
    .cpu_addr     (cpu_addr),
    .cpu_dout     (cpu_dout),
    .cpu_mem_wr   (cpu_mem_wr),
    .bank_mask    (bank_mask),
    .rom_addr     (rom_addr),
    .rom_sel      (rom_sel),
    .cart_ram_sel (cart_ram_sel),
    .cart_ram_addr(cart_ram_addr),
    .sys_ram_sel  (sys_ram_sel),
    .sys_ram_addr (sys_ram_addr),
    .map_ctrl     (map_ctrl),
    .map_bank0    (map_bank0),
    .map_bank1    (map_bank1),
    .map_bank2    (map_bank2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: the four mapper registers and whether the current Z80
  // write cycle has already been consumed.
  logic [7:0] m_reg [4];
  bit         m_cycle_used;
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs seen at the edge drive the model afterwards.
  task automatic tick();
    bit          r, w, e;
    logic [15:0] a;
    logic [7:0]  d;
    int          idx;
    r = reset; w = cpu_mem_wr; e = cpu_clk_edge; a = cpu_addr; d = cpu_dout;
    @(posedge clk);
    #1;
    cpu_clk_edge = 1'b0;
    if (r) begin
      m_reg[0] = 8'h00; m_reg[1] = 8'd0; m_reg[2] = 8'd1; m_reg[3] = 8'd2;
      m_cycle_used = 1'b0;
    end else if (!w) begin
      m_cycle_used = 1'b0;
    end else if (e && !m_cycle_used) begin
      m_cycle_used = 1'b1;
      if (int'(a) >= 'hFFFC) begin
        idx = int'(a) - 'hFFFC;
        m_reg[idx] = d;
      end
    end
  endtask

  // One Z80 write cycle with the strobe held across several enable pulses.
  task automatic write_cycle(input logic [15:0] a, input logic [7:0] d, input int pulses);
    cpu_addr   = a;
    cpu_dout   = d;
    cpu_mem_wr = 1'b1;
    tick();
    for (int p = 0; p < pulses; p++) begin
      cpu_clk_edge = 1'b1;
      tick();
      tick();
    end
    cpu_mem_wr = 1'b0;
    tick();
  endtask

  task automatic read(input logic [15:0] a);
    cpu_addr = a;
    #1;
  endtask

  // Memory-map model expressed as plain arithmetic on the address.
  always @(negedge clk) begin
    if (chk_en) begin
      int a, slot, bank, e_rom, e_cart, e_sys;
      a = int'(cpu_addr);
      e_rom = 0; e_cart = 0; e_sys = 0;
      if (a >= 'hC000) e_sys = 1;
      else if (a >= 'h8000 && m_reg[0][3]) e_cart = 1;
      else e_rom = 1;

      chk("map_ctrl",  map_ctrl,  m_reg[0]);
      chk("map_bank0", map_bank0, m_reg[1]);
      chk("map_bank1", map_bank1, m_reg[2]);
      chk("map_bank2", map_bank2, m_reg[3]);
      chk("rom_sel",      rom_sel,      e_rom);
      chk("cart_ram_sel", cart_ram_sel, e_cart);
      chk("sys_ram_sel",  sys_ram_sel,  e_sys);

      if (e_rom != 0) begin
        if (a < 'h400) begin
          chk("rom_addr_unpaged", rom_addr, a);
        end else begin
          slot = a / 'h4000;
          bank = int'(m_reg[slot + 1] & bank_mask);
          chk("rom_addr", rom_addr, bank * 'h4000 + a % 'h4000);
        end
      end
      if (e_cart != 0)
        chk("cart_ram_addr", cart_ram_addr, (m_reg[0][2] ? 'h4000 : 0) + a % 'h4000);
      if (e_sys != 0)
        chk("sys_ram_addr", sys_ram_addr, a % 'h2000);
    end
  end

  initial begin
    reset        = 1'b1;
    cpu_clk_edge = 1'b0;
    cpu_addr     = 16'h0000;
    cpu_dout     = 8'h00;
    cpu_mem_wr   = 1'b0;
    bank_mask    = 8'hFF;
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();

    // Reset state
    read(16'h4123);
    chk("lit_rst_rom_addr", rom_addr, 24'h004123);
    chk("lit_rst_rom_sel",  rom_sel,  1'b1);
    read(16'h8000);
    chk("lit_rst_rom_8000", rom_addr, 24'h008000);
    chk("lit_rst_bank1",    map_bank1, 8'd1);
    chk("lit_rst_ctrl",     map_ctrl,  8'h00);
    tick();

    // One capture across three enable pulses
    write_cycle(16'hFFFE, 8'h05, 3);
    chk("lit_bank1_5", map_bank1, 8'd5);
    read(16'h7FFF);
    chk("lit_rom_7fff", rom_addr, 24'h017FFF);
    tick();

    // Bank wrap through the mask
    bank_mask = 8'h07;
    write_cycle(16'hFFFF, 8'h0D, 2);
    read(16'h8010);
    chk("lit_rom_wrap", rom_addr, 24'h014010);
    tick();

    // Cartridge RAM in slot 2, upper half
    write_cycle(16'hFFFC, 8'h0C, 1);
    read(16'hA001);
    chk("lit_cart_sel",  cart_ram_sel,  1'b1);
    chk("lit_cart_addr", cart_ram_addr, 15'h6001);
    chk("lit_cart_rom0", rom_sel,       1'b0);
    tick();
    write_cycle(16'hFFFC, 8'h00, 1);
    read(16'hA001);
    chk("lit_cart_off_rom", rom_sel,  1'b1);
    chk("lit_cart_off_adr", rom_addr, 24'h016001);
    tick();

    // Unpaged first 1K vs paged slot 0
    write_cycle(16'hFFFD, 8'h02, 2);
    read(16'h0200);
    chk("lit_unpaged", rom_addr, 24'h000200);
    read(16'h03FF);
    chk("lit_unpaged_top", rom_addr, 24'h0003FF);
    read(16'h0400);
    chk("lit_paged_0400", rom_addr, 24'h008400);
    tick();

    // System RAM with mirror
    read(16'hF234);
    chk("lit_sys_sel",  sys_ram_sel,  1'b1);
    chk("lit_sys_addr", sys_ram_addr, 13'h1234);
    tick();
    read(16'hC000);
    tick();

    // Mask wide open: full bank number used
    bank_mask = 8'hFF;
    read(16'h8010);
    chk("lit_nowrap", rom_addr, 24'h034010);
    tick();

    // Non-mapper write leaves registers alone; back-to-back mapper writes
    write_cycle(16'hC123, 8'h77, 2);
    write_cycle(16'hFFFD, 8'h81, 1);
    write_cycle(16'hFFFE, 8'hC3, 2);
    read(16'h4001);
    chk("lit_bank1_c3", rom_addr, 24'h30C001);
    tick();

    // Reset asserted during a write to FFFF
    cpu_addr     = 16'hFFFF;
    cpu_dout     = 8'h33;
    cpu_mem_wr   = 1'b1;
    reset        = 1'b1;
    cpu_clk_edge = 1'b1;
    tick();
    cpu_clk_edge = 1'b1;
    tick();
    chk("lit_rst_mid_bank2", map_bank2, 8'd2);
    reset = 1'b0;
    tick();
    chk("lit_rst_rel_bank2", map_bank2, 8'd2);
    cpu_clk_edge = 1'b1;
    tick();
    chk("lit_post_rst_wr", map_bank2, 8'h33);
    cpu_mem_wr = 1'b0;
    tick();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
